ex_forward_ctrl: RTL and testbench
==================================

// Module: ex_forward_ctrl
// PURPOSE
//  Hazard/forwarding controller driving the 2-bit selects of the two EX-stage operand
//  4:1 muxes (operand A, operand B) in the 5-stage pipeline. Tracks destination-register
//  metadata through its own EX, MEM and WB slots, computes forwarding selects, detects
//  load-use hazards (stall_o) and counts stall cycles. Data values never pass through it.
// PARAMETERS
//  RA_W   5   register address width (x0..x31)
//  CNT_W  32  stall counter width
// PORTS
//  clk_i         in   1       clock, all state updates on rising edge
//  rst_i         in   1       synchronous reset, active-low
//  id_rs1_i      in   RA_W    rs1 of instruction in ID
//  id_rs2_i      in   RA_W    rs2 of instruction in ID
//  id_use_rs1_i  in   1       ID instruction reads rs1
//  id_use_rs2_i  in   1       ID instruction reads rs2
//  id_rd_i       in   RA_W    rd of instruction in ID
//  id_regwr_i    in   1       ID instruction writes rd
//  id_memrd_i    in   1       ID instruction is a load
//  flush_i       in   1       squash ID instruction (taken branch/jump)
//  fwd_a_o       out  2       select for operand-A mux
//  fwd_b_o       out  2       select for operand-B mux
//  stall_o       out  1       hold PC and IF/ID, insert bubble into EX
//  stall_cnt_o   out  CNT_W   saturating count of stall cycles
// BEHAVIOUR
//  Slots: EX{rs1,rs2,use1,use2,rd,regwr,memrd}, MEM{rd,regwr,memrd}, WB{rd,regwr}.
//  Bubble = regwr=0, memrd=0, use1=use2=0 (rd/rs fields don't-care).
//  Reset (rst_i=0 at edge): all slots bubble, stall_cnt_o=0; hence fwd_a_o=fwd_b_o=00,
//   stall_o=0 in the first cycle after reset. Reset mid-stall aborts the stall.
//  Every cycle (no enable): MEM<=EX, WB<=MEM.
//  EX load: if flush_i or stall_o -> EX<=bubble; else EX<=ID fields.
//  stall_o (combinational) = !flush_i & EX.memrd & EX.rd!=0 &
//   ((id_use_rs1_i & id_rs1_i==EX.rd) | (id_use_rs2_i & id_rs2_i==EX.rd)).
//   flush_i overrides: squashed instruction never stalls. Stall lasts exactly 1 cycle
//   per load-use (bubble advances load to MEM, then MEM->WB forwarding applies).
//  Select encoding (per operand, from EX slot, combinational, 0 latency):
//   10 = EX/MEM result, when MEM.regwr & MEM.rd!=0 & MEM.rd==EX.rsN & EX.useN
//   01 = MEM/WB writeback data, when WB.regwr & WB.rd!=0 & WB.rd==EX.rsN & EX.useN
//   00 = register file value otherwise; 11 never driven.
//   Priority: 10 over 01 (newest producer wins). x0 never forwarded.
//   MEM.memrd & match is not a hazard at select time (stall already separated it).
//  stall_cnt_o: +1 on every edge where stall_o=1 and rst_i=1; saturates at all-ones.
//  Simultaneous flush_i and load-use match: stall_o=0, EX<=bubble, counter unchanged.
//  ID inputs must be stable before edge; outputs glitch-free only after settle (no regs
//   on fwd/stall outputs -- they feed same-cycle muxes and PC enable).
// TESTING
//  1 Reset: hold rst_i=0 3 cycles with random ID inputs -> fwd 00/00, stall 0, cnt 0.
//  2 Back-to-back: add x5 (rd=5,regwr) then sub rs1=x5 -> next cycle fwd_a_o=10;
//    with one unrelated instr between -> fwd_a_o=01; both producers write x5 -> 10.
//  3 x0: producer rd=0 regwr=1, consumer rs1=rs2=0 -> fwd_a_o=fwd_b_o=00.
//  4 Load-use: lw x7 then add rs2=x7 -> stall_o=1 exactly 1 cycle, cnt 0->1,
//    then fwd_b_o=01 for the add in EX; use_rs2=0 same regs -> no stall.
//  5 Flush vs stall: lw x7 then add rs1=x7 with flush_i=1 -> stall_o=0, cnt unchanged,
//    following cycle EX bubble -> fwd 00/00.
//  6 Saturation: CNT_W=3, force 9 load-use stalls -> stall_cnt_o stops at 7.

Source files
------------

// File: rtl/ex_forward_ctrl.sv
// ex_forward_ctrl
// ---------------------------------------------------------------------------
// Forwarding and load-use hazard controller for the EX stage of a 5-stage
// pipeline. Only register-address metadata is tracked here; the data values
// themselves never pass through this block.
//
// Internal slots (mirroring the pipeline registers):
//   EX  : rs1, rs2, use1, use2, rd, regwr, memrd
//   MEM : rd, regwr, memrd
//   WB  : rd, regwr
//
// Ports:
//   clk_i         in   1      clock, all state updates on the rising edge
//   rst_i         in   1      synchronous reset, active-low
//   id_rs1_i      in   RA_W   rs1 of the instruction in ID
//   id_rs2_i      in   RA_W   rs2 of the instruction in ID
//   id_use_rs1_i  in   1      ID instruction reads rs1
//   id_use_rs2_i  in   1      ID instruction reads rs2
//   id_rd_i       in   RA_W   rd of the instruction in ID
//   id_regwr_i    in   1      ID instruction writes rd
//   id_memrd_i    in   1      ID instruction is a load
//   flush_i       in   1      squash the ID instruction (taken branch/jump)
//   fwd_a_o       out  2      operand-A mux select (10 MEM, 01 WB, 00 regfile)
//   fwd_b_o       out  2      operand-B mux select (10 MEM, 01 WB, 00 regfile)
//   stall_o       out  1      hold PC and IF/ID, insert a bubble into EX
//   stall_cnt_o   out  CNT_W  saturating count of stall cycles
// ---------------------------------------------------------------------------
module ex_forward_ctrl #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [RA_W-1:0]  id_rs1_i,
    input  logic [RA_W-1:0]  id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [RA_W-1:0]  id_rd_i,
    input  logic             id_regwr_i,
    input  logic             id_memrd_i,
    input  logic             flush_i,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             stall_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    // EX slot
    logic [RA_W-1:0]  r_ex_rs1;
    logic [RA_W-1:0]  r_ex_rs2;
    logic             r_ex_use1;
    logic             r_ex_use2;
    logic [RA_W-1:0]  r_ex_rd;
    logic             r_ex_regwr;
    logic             r_ex_memrd;
    // MEM slot
    logic [RA_W-1:0]  r_mem_rd;
    logic             r_mem_regwr;
    logic             r_mem_memrd;
    // WB slot
    logic [RA_W-1:0]  r_wb_rd;
    logic             r_wb_regwr;
    // stall statistics
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_stall;
    logic             w_ex_load_nz;
    logic             w_hit_rs1;
    logic             w_hit_rs2;
    logic             w_mem_fwd_ok;
    logic             w_wb_fwd_ok;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;
    logic             w_cnt_full;

    // ---------------------------------------------------------------------
    // Load-use detection: a load sitting in EX whose rd is read by the ID
    // instruction cannot be forwarded in time. A squashed ID instruction
    // never stalls, so flush takes precedence.
    // ---------------------------------------------------------------------
    assign w_ex_load_nz = r_ex_memrd && (r_ex_rd != '0);
    assign w_hit_rs1    = id_use_rs1_i && (id_rs1_i == r_ex_rd);
    assign w_hit_rs2    = id_use_rs2_i && (id_rs2_i == r_ex_rd);
    assign w_stall      = !flush_i && w_ex_load_nz && (w_hit_rs1 || w_hit_rs2);

    // ---------------------------------------------------------------------
    // Forwarding selects. The MEM producer is newer than the WB producer,
    // so it wins when both write the same register. x0 is never forwarded.
    // A load in MEM matching here is not a hazard: the stall bubble has
    // already pushed any dependent instruction one stage further back.
    // ---------------------------------------------------------------------
    assign w_mem_fwd_ok = r_mem_regwr && (r_mem_rd != '0);
    assign w_wb_fwd_ok  = r_wb_regwr  && (r_wb_rd  != '0);

    always_comb begin
        w_fwd_a = 2'b00;
        if (r_ex_use1 && w_mem_fwd_ok && (r_mem_rd == r_ex_rs1)) begin
            w_fwd_a = 2'b10;
        end else if (r_ex_use1 && w_wb_fwd_ok && (r_wb_rd == r_ex_rs1)) begin
            w_fwd_a = 2'b01;
        end
    end

    always_comb begin
        w_fwd_b = 2'b00;
        if (r_ex_use2 && w_mem_fwd_ok && (r_mem_rd == r_ex_rs2)) begin
            w_fwd_b = 2'b10;
        end else if (r_ex_use2 && w_wb_fwd_ok && (r_wb_rd == r_ex_rs2)) begin
            w_fwd_b = 2'b01;
        end
    end

    // ---------------------------------------------------------------------
    // Slot pipeline. MEM and WB advance unconditionally; EX takes a bubble
    // on flush or stall, otherwise the ID fields.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_ex_rs1    <= '0;
            r_ex_rs2    <= '0;
            r_ex_use1   <= 1'b0;
            r_ex_use2   <= 1'b0;
            r_ex_rd     <= '0;
            r_ex_regwr  <= 1'b0;
            r_ex_memrd  <= 1'b0;
            r_mem_rd    <= '0;
            r_mem_regwr <= 1'b0;
            r_mem_memrd <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_regwr  <= 1'b0;
        end else begin
            r_mem_rd    <= r_ex_rd;
            r_mem_regwr <= r_ex_regwr;
            r_mem_memrd <= r_ex_memrd;
            r_wb_rd     <= r_mem_rd;
            r_wb_regwr  <= r_mem_regwr;
            if (flush_i || w_stall) begin
                r_ex_rs1   <= '0;
                r_ex_rs2   <= '0;
                r_ex_use1  <= 1'b0;
                r_ex_use2  <= 1'b0;
                r_ex_rd    <= '0;
                r_ex_regwr <= 1'b0;
                r_ex_memrd <= 1'b0;
            end else begin
                r_ex_rs1   <= id_rs1_i;
                r_ex_rs2   <= id_rs2_i;
                r_ex_use1  <= id_use_rs1_i;
                r_ex_use2  <= id_use_rs2_i;
                r_ex_rd    <= id_rd_i;
                r_ex_regwr <= id_regwr_i;
                r_ex_memrd <= id_memrd_i;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stall counter, saturating at all-ones.
    // ---------------------------------------------------------------------
    assign w_cnt_full = &r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !w_cnt_full) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign fwd_a_o     = w_fwd_a;
    assign fwd_b_o     = w_fwd_b;
    assign stall_o     = w_stall;
    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_ex_forward_ctrl.sv
// Directed bench for ex_forward_ctrl. Two instances share the stimulus: one
// with the default 32-bit counter and one with a 3-bit counter to exercise
// saturation.
module tb_ex_forward_ctrl;

    localparam int RA_W = 5;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [RA_W-1:0] id_rs1_i;
    logic [RA_W-1:0] id_rs2_i;
    logic            id_use_rs1_i;
    logic            id_use_rs2_i;
    logic [RA_W-1:0] id_rd_i;
    logic            id_regwr_i;
    logic            id_memrd_i;
    logic            flush_i;

    logic [1:0]      fwd_a_o;
    logic [1:0]      fwd_b_o;
    logic            stall_o;
    logic [31:0]     stall_cnt_o;

    logic [1:0]      s_fwd_a_o;
    logic [1:0]      s_fwd_b_o;
    logic            s_stall_o;
    logic [2:0]      s_stall_cnt_o;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    ex_forward_ctrl #(.RA_W(RA_W), .CNT_W(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .id_rs1_i     (id_rs1_i),
        .id_rs2_i     (id_rs2_i),
        .id_use_rs1_i (id_use_rs1_i),
        .id_use_rs2_i (id_use_rs2_i),
        .id_rd_i      (id_rd_i),
        .id_regwr_i   (id_regwr_i),
        .id_memrd_i   (id_memrd_i),
        .flush_i      (flush_i),
        .fwd_a_o      (fwd_a_o),
        .fwd_b_o      (fwd_b_o),
        .stall_o      (stall_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    ex_forward_ctrl #(.RA_W(RA_W), .CNT_W(3)) dut_sat (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .id_rs1_i     (id_rs1_i),
        .id_rs2_i     (id_rs2_i),
        .id_use_rs1_i (id_use_rs1_i),
        .id_use_rs2_i (id_use_rs2_i),
        .id_rd_i      (id_rd_i),
        .id_regwr_i   (id_regwr_i),
        .id_memrd_i   (id_memrd_i),
        .flush_i      (flush_i),
        .fwd_a_o      (s_fwd_a_o),
        .fwd_b_o      (s_fwd_b_o),
        .stall_o      (s_stall_o),
        .stall_cnt_o  (s_stall_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-16s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive the ID-stage instruction (flush cleared).
    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic mr);
        id_rs1_i     = rs1;
        id_rs2_i     = rs2;
        id_use_rs1_i = u1;
        id_use_rs2_i = u2;
        id_rd_i      = rd;
        id_regwr_i   = rw;
        id_memrd_i   = mr;
        flush_i      = 1'b0;
    endtask

    task automatic nop();
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Advance one clock edge and settle.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b0;
        nop();

        // 1: reset held 3 cycles with random ID inputs
        for (int i = 0; i < 3; i++) begin
            set_id(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                   5'($urandom), 1'($urandom), 1'($urandom));
            flush_i = 1'($urandom);
            tick();
        end
        nop();
        #1;
        check("rst_fwd_a", 32'(fwd_a_o), 32'd0);
        check("rst_fwd_b", 32'(fwd_b_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_cnt",   stall_cnt_o,  32'd0);
        rst_i = 1'b1;

        // 2a: add x5 then sub rs1=x5 -> 10
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0); tick();
        set_id(5'd5, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0); tick();
        nop(); #1;
        check("b2b_fwd_a", 32'(fwd_a_o), 32'b10);
        check("b2b_fwd_b", 32'(fwd_b_o), 32'b00);

        // 2b: one unrelated instruction in between -> 01
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0); tick();
        set_id(5'd3, 5'd4, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0); tick();
        set_id(5'd5, 5'd3, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0); tick();
        nop(); #1;
        check("gap_fwd_a", 32'(fwd_a_o), 32'b01);
        check("gap_fwd_b", 32'(fwd_b_o), 32'b00);

        // 2c: both producers write x5 -> newest (MEM) wins; rs2 also x5
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0); tick();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0); tick();
        set_id(5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0); tick();
        nop(); #1;
        check("dbl_fwd_a", 32'(fwd_a_o), 32'b10);
        check("dbl_fwd_b", 32'(fwd_b_o), 32'b10);

        // 3: x0 never forwarded
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0); tick();
        set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0); tick();
        nop(); #1;
        check("x0_fwd_a", 32'(fwd_a_o), 32'b00);
        check("x0_fwd_b", 32'(fwd_b_o), 32'b00);

        // 4: lw x7 then add rs2=x7 -> one stall, then WB forwarding on B
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1); tick();
        set_id(5'd7, 5'd7, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0); #1;
        check("lu_stall_on",  32'(stall_o), 32'd1);
        check("lu_cnt_before", stall_cnt_o, 32'd0);
        tick();
        check("lu_stall_off", 32'(stall_o), 32'd0);
        check("lu_cnt_after",  stall_cnt_o, 32'd1);
        tick();
        nop(); #1;
        check("lu_fwd_b", 32'(fwd_b_o), 32'b01);
        check("lu_fwd_a", 32'(fwd_a_o), 32'b00);

        // 4b: same registers but rs2 not read -> no stall
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1); tick();
        set_id(5'd3, 5'd7, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0); #1;
        check("nouse_stall", 32'(stall_o), 32'd0);
        tick();
        check("nouse_cnt", stall_cnt_o, 32'd1);

        // 5: flush overrides load-use
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1); tick();
        set_id(5'd7, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
        flush_i = 1'b1; #1;
        check("flush_stall", 32'(stall_o), 32'd0);
        tick();
        nop(); #1;
        check("flush_cnt",   stall_cnt_o,    32'd1);
        check("flush_fwd_a", 32'(fwd_a_o),   32'b00);
        check("flush_fwd_b", 32'(fwd_b_o),   32'b00);

        // 6: nine load-use stalls; 3-bit counter saturates at 7
        check("sat_cnt_start", 32'(s_stall_cnt_o), 32'd1);
        for (int i = 0; i < 9; i++) begin
            set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1); tick();
            set_id(5'd7, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0); #1;
            check("sat_stall", 32'(stall_o), 32'd1);
            tick();
            tick();
        end
        nop(); #1;
        check("sat_cnt_small", 32'(s_stall_cnt_o), 32'd7);
        check("sat_cnt_big",   stall_cnt_o,        32'd10);

        // Reset mid-stall aborts the stall and clears the counter
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1); tick();
        set_id(5'd7, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0); #1;
        check("mid_stall_on", 32'(stall_o), 32'd1);
        rst_i = 1'b0;
        tick();
        check("mid_stall_off", 32'(stall_o), 32'd0);
        check("mid_cnt",       stall_cnt_o,  32'd0);
        rst_i = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
